// File: rtl/lsu_req_queue_if.sv
// lsu_req_queue_if: request, memory-port and response signals of the load/store request queue
interface lsu_req_queue_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [13:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       op_code;
    logic [13:0]      rwaddr;
    logic [31:0]      wdata;
    logic             stall;
    logic [31:0]      rdata;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_tag, rdata,
        output req_ready, op_code, rwaddr, wdata, stall, rsp_valid, rsp_tag, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_tag, rdata,
        input  req_ready, op_code, rwaddr, wdata, stall, rsp_valid, rsp_tag, rsp_data, rsp_err
    );
endinterface

// File: rtl/lsu_req_queue.sv
// lsu_req_queue: load/store request FIFO with alignment check, one memory issue per cycle and in-order responses
module lsu_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int MEM_LAT = 1
) (
    input logic            clk,
    input logic            nrst,
    lsu_req_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [2:0]       q_op    [DEPTH];
    logic [13:0]      q_addr  [DEPTH];
    logic [31:0]      q_wdata [DEPTH];
    logic [TAG_W-1:0] q_tag   [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, next_count;
    logic             push, pop;
    logic [2:0]       head_op;
    logic [13:0]      head_addr;
    logic             head_half, head_word, head_load, head_mis;
    logic             pv   [MEM_LAT+1];
    logic [TAG_W-1:0] ptag [MEM_LAT+1];
    logic             perr [MEM_LAT+1];
    logic             pld  [MEM_LAT+1];

    assign push       = bus.req_valid & bus.req_ready;
    assign pop        = count != '0;
    assign next_count = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign head_op    = q_op[rd_ptr];
    assign head_addr  = q_addr[rd_ptr];
    assign head_half  = head_op inside {3'b001, 3'b101, 3'b110};
    assign head_word  = head_op inside {3'b010, 3'b111};
    assign head_load  = !(head_op inside {3'b011, 3'b110, 3'b111});
    assign head_mis   = (head_half & head_addr[0]) | (head_word & |head_addr[1:0]);

    always_ff @(posedge clk)
        if (push) begin
            q_op[wr_ptr]    <= bus.req_op;
            q_addr[wr_ptr]  <= bus.req_addr;
            q_wdata[wr_ptr] <= bus.req_wdata;
            q_tag[wr_ptr]   <= bus.req_tag;
        end

    // Misaligned heads are popped like any other but leave the memory port stalled
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.req_ready <= 1'b0;
            bus.op_code   <= '0;
            bus.rwaddr    <= '0;
            bus.wdata     <= '0;
            bus.stall     <= 1'b1;
        end else begin
            wr_ptr        <= wr_ptr + AW'(push);
            rd_ptr        <= rd_ptr + AW'(pop);
            count         <= next_count;
            bus.req_ready <= next_count != FULL;
            bus.stall     <= !pop | head_mis;
            if (pop & !head_mis) begin
                bus.op_code <= head_op;
                bus.rwaddr  <= head_addr;
                bus.wdata   <= q_wdata[rd_ptr];
            end
        end

    // Errors ride the same pipe as memory accesses so responses never reorder
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                pv[i]   <= 1'b0;
                ptag[i] <= '0;
                perr[i] <= 1'b0;
                pld[i]  <= 1'b0;
            end
            bus.rsp_valid <= 1'b0;
            bus.rsp_tag   <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            pv[0]   <= pop;
            ptag[0] <= q_tag[rd_ptr];
            perr[0] <= head_mis;
            pld[0]  <= head_load;
            for (int i = 1; i <= MEM_LAT; i++) begin
                pv[i]   <= pv[i-1];
                ptag[i] <= ptag[i-1];
                perr[i] <= perr[i-1];
                pld[i]  <= pld[i-1];
            end
            bus.rsp_valid <= pv[MEM_LAT];
            bus.rsp_tag   <= pv[MEM_LAT] ? ptag[MEM_LAT] : '0;
            bus.rsp_err   <= pv[MEM_LAT] & perr[MEM_LAT];
            bus.rsp_data  <= (pv[MEM_LAT] & pld[MEM_LAT] & !perr[MEM_LAT]) ? bus.rdata : '0;
        end
endmodule
